// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: operand sequencer and result collector for a bit-serial adder.
// Takes two parallel operands, clears the adder, streams the operands LSB-first,
// and gathers the adder's registered z output back into a parallel WIDTH+1 sum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; ready
// S_CLR   | one cycle holding the adder in clear
// S_SHIFT | WIDTH+1 cycles presenting operand bits (last one is 0/0)
// S_DRAIN | one cycle capturing the final z (the carry)
// S_DONE  | one-cycle done pulse; can accept the next start
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             add_clr,
  output logic             x_out,
  output logic             y_out,
  input  logic             z_in
);

  localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds result bits 0..WIDTH-1; the carry is taken straight from z_in in DRAIN.
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CNT_LAST) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_CLR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    add_clr = 1'b0;
    x_out   = 1'b0;
    y_out   = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_CLR: begin
        busy    = 1'b1;
        add_clr = 1'b1;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        x_out = a_sh[0];
        y_out = b_sh[0];
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        done  = 1'b1;
        ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand shifters, bit counter, result collection and sum update.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      sum    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          // z lags x/y by one cycle, so the first SHIFT cycle has nothing valid yet.
          if (cnt != '0) res_sh <= (res_sh >> 1) | (WIDTH'(z_in) << (WIDTH - 1));
        end
        S_DRAIN: sum <= {z_in, res_sh};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 1-bit instance, each driving a
// behavioural bit-serial adder; expected sums go through a queue per instance.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       reset;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready, busy, done, add_clr, x_out, y_out, z_in;
  logic [8:0] sum;

  logic       w1_start;
  logic [0:0] w1_a;
  logic [0:0] w1_b;
  logic       w1_ready, w1_busy, w1_done, w1_add_clr, w1_x, w1_y, w1_z;
  logic [1:0] w1_sum;

  logic       carry8, carry1;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [8:0] vsum;
  } vec_t;

  vec_t vecs[7];

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum),
    .add_clr(add_clr), .x_out(x_out), .y_out(y_out), .z_in(z_in)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset), .start(w1_start), .a(w1_a), .b(w1_b),
    .ready(w1_ready), .busy(w1_busy), .done(w1_done), .sum(w1_sum),
    .add_clr(w1_add_clr), .x_out(w1_x), .y_out(w1_y), .z_in(w1_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial adder models: registered sum bit and carry, cleared by add_clr.
  always @(posedge clk) begin
    if (add_clr) begin
      z_in   <= 1'b0;
      carry8 <= 1'b0;
    end else begin
      z_in   <= x_out ^ y_out ^ carry8;
      carry8 <= (x_out & y_out) | (x_out & carry8) | (y_out & carry8);
    end
  end

  always @(posedge clk) begin
    if (w1_add_clr) begin
      w1_z   <= 1'b0;
      carry1 <= 1'b0;
    end else begin
      w1_z   <= w1_x ^ w1_y ^ carry1;
      carry1 <= (w1_x & w1_y) | (w1_x & carry1) | (w1_y & carry1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance: every done pops one expected sum.
  always @(negedge clk) begin
    if (!reset && done) begin
      check("w8_done_not_busy", {31'b0, busy}, 32'd0);
      if (exp_q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w8_unexpected_done actual=1 expected=0 sum=%0h", sum);
      end else begin
        check("w8_sum", {23'b0, sum}, {23'b0, exp_q8.pop_front()});
      end
    end
  end

  // Scoreboard for the 1-bit instance.
  always @(negedge clk) begin
    if (!reset && w1_done) begin
      if (exp_q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w1_unexpected_done actual=1 expected=0 sum=%0h", w1_sum);
      end else begin
        check("w1_sum", {30'b0, w1_sum}, {30'b0, exp_q1.pop_front()});
      end
    end
  end

  // Count edges until done is seen on the following negedge (bounded).
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL w8_timeout actual=no_done expected=done");
    end
  endtask

  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [8:0] es);
    int n;
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk);
    exp_q8.push_back(es);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    wait_done8(n);
    check("w8_latency", n, 11);
    @(posedge clk);
    #1;
    check("w8_done_pulse", {31'b0, done}, 32'd0);
    check("w8_ready_after", {31'b0, ready}, 32'd1);
  endtask

  initial begin : main
    int n;
    logic [8:0] xa;
    logic [8:0] yb;

    vecs[0] = '{8'h5A, 8'h3C, 9'h096};
    vecs[1] = '{8'hFF, 8'h01, 9'h100};
    vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
    vecs[3] = '{8'h00, 8'h00, 9'h000};
    vecs[4] = '{8'h01, 8'h02, 9'h003};
    vecs[5] = '{8'h80, 8'h80, 9'h100};
    vecs[6] = '{8'hAA, 8'h55, 9'h0FF};

    reset = 1'b1;
    start = 1'b0; a = '0; b = '0;
    w1_start = 1'b0; w1_a = '0; w1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_add_clr", {31'b0, add_clr}, 32'd0);
    check("rst_x_out", {31'b0, x_out}, 32'd0);
    check("rst_y_out", {31'b0, y_out}, 32'd0);
    check("rst_sum", {23'b0, sum}, 32'd0);
    check("rst_w1_ready", {31'b0, w1_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_op(vecs[i].va, vecs[i].vb, vecs[i].vsum);

    // Serial stream of 0x5A + 0x3C: CLR, then 9 SHIFT bits, DRAIN, DONE.
    xa = {1'b0, 8'h5A};
    yb = {1'b0, 8'h3C};
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(posedge clk);
    exp_q8.push_back(9'h096);
    #1;
    start = 1'b0;
    check("clr_add_clr", {31'b0, add_clr}, 32'd1);
    check("clr_busy", {31'b0, busy}, 32'd1);
    check("clr_x_out", {31'b0, x_out}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      check("shift_x_out", {31'b0, x_out}, {31'b0, xa[i]});
      check("shift_y_out", {31'b0, y_out}, {31'b0, yb[i]});
      check("shift_add_clr", {31'b0, add_clr}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("drain_busy", {31'b0, busy}, 32'd1);
    check("drain_x_out", {31'b0, x_out}, 32'd0);
    @(posedge clk);
    #1;
    check("done_flag", {31'b0, done}, 32'd1);
    check("done_ready", {31'b0, ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back: start held through DONE; the second op must see a cleared carry.
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    exp_q8.push_back(9'h1FE);
    #1;
    a = 8'h00; b = 8'h00;
    wait_done8(n);
    check("b2b_first_latency", n, 11);
    exp_q8.push_back(9'h000);
    @(posedge clk);
    #1;
    start = 1'b0;
    // The DONE-exit edge accepted directly, so CLR follows DONE with no idle gap.
    check("b2b_accept_clr", {31'b0, add_clr}, 32'd1);
    wait_done8(n);
    check("b2b_second_latency", n, 11);
    @(posedge clk);
    #1;

    // start pulsed mid-SHIFT is ignored.
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk);
    exp_q8.push_back(9'h046);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done8(n);
    check("ignore_latency", n + 5, 11);
    repeat (15) @(posedge clk);
    #1;

    // Reset at cnt=4 aborts the op with no done.
    start = 1'b1; a = 8'hFF; b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_sum", {23'b0, sum}, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("midrst_sum_held", {23'b0, sum}, 32'd0);
    run_op(8'h01, 8'h02, 9'h003);

    // WIDTH=1 instance: 1+1 = 2'b10, done 4 cycles after acceptance.
    w1_start = 1'b1; w1_a = 1'b1; w1_b = 1'b1;
    @(posedge clk);
    exp_q1.push_back(2'b10);
    #1;
    w1_start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!w1_done && n < 20);
    check("w1_latency", n, 4);
    repeat (5) @(posedge clk);
    #1;

    check("w8_queue_empty", exp_q8.size(), 0);
    check("w1_queue_empty", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
